pwl_sigmoid_backward: RTL and testbench
=======================================

Name: pwl_sigmoid_backward

Overview:
- Backward-pass (gradient) counterpart of the forward PWL sigmoid activation; used in the discriminator/generator training path.
- Consumes the saved forward output y = sigmoid(x) and the upstream gradient g, both Q8.8.
- Produces dL/dx = g · y · (1 − y) in Q8.8.
- Two-stage pipeline with valid/ready backpressure, so it can sit between stalling producers and consumers in the backprop datapath.

Parameters:
- DATA_W, 16, width of all Q8.8 data ports; the block is only specified for 16.
- FRAC_W, 8, number of fractional bits; fixed at 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts the beat this cycle
- y_in  in  16  signed Q8.8 saved forward sigmoid output; nominal range 0..256
- grad_in  in  16  signed Q8.8 upstream gradient
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- grad_out  out  16  signed Q8.8 dL/dx

Behaviour:
- Reset is synchronous and active-high: on a clk edge with rst=1, both stage valids, out_valid, grad_out and the internal stage registers clear to 0.
  - rst dominates any handshake in the same cycle; in-flight beats are dropped.
  - in_ready is 1 on the first cycle after rst deasserts, provided the pipeline is empty.
- Handshake:
  - A beat transfers on an edge where valid && ready.
  - out_valid and grad_out hold stable while out_valid=1 && out_ready=0.
  - in_ready is combinational: in_ready = !s1_valid || s1_ready, where s1_ready = !s2_valid || out_ready. There is no combinational path from in_valid to out_valid.
- Latency and throughput:
  - Exactly 2 cycles from an accepted input to out_valid when there is no backpressure.
  - Sustains 1 beat/cycle.
  - At most 2 beats in flight. Order is preserved; no beat is dropped or duplicated.
- Stage 1 (on input accept):
  - yc = clamp(y_in, 0, 256).
  - s = (yc · (256 − yc)) >> 8, unsigned 7-bit, range 0..64.
  - Register s and grad_in.
- Stage 2 (on stage-1 → stage-2 transfer):
  - p = grad_in (signed 16) × s (zero-extended), 24-bit signed.
  - grad_out = p >>> 8 (arithmetic shift = floor), bits [23:8] taken as in the forward block.
  - Result range −8192..8191; no saturation is required.
- Boundaries:
  - y_in < 0 → yc = 0; y_in > 256 → yc = 256; both give s = 0 and grad_out = 0.
  - y_in = 128 gives the maximum s = 64.
  - Simultaneous out-drain and in-accept while full is legal and moves the pipeline forward by one.

Optional Feature:
- Macro: PWL_SIG_BWD_CLAMP_CNT_EN.
- When defined:
  - Extra output port clamp_cnt, out, 16 bits.
  - Increments by 1 on every accepted input whose y_in is outside 0..256.
  - Saturates at 16'hFFFF (no wrap). Cleared by rst.
- When undefined: the port and its counter are absent; the datapath is identical either way.

Decomposition:
- Package pwl_sigmoid_pkg:
  - Q8.8 constants: ONE_Q88 = 256, FRAC_W = 8, DATA_W = 16.
  - Clamp bounds Y_MIN = 0, Y_MAX = 256.
  - Shared with the forward sigmoid block.
- One natural sub-module, pwl_pipe_stage: a generic valid/ready register slice parameterised by payload width, instantiated twice. All arithmetic lives in the top module.

Test Plan:
- y_in=128, grad_in=256, out_ready=1 → grad_out=64, out_valid exactly 2 cycles after accept.
- y_in=64, grad_in=−256 → s=48, grad_out=−48. y_in=128, grad_in=−1 → grad_out=−1 (floor check).
- y_in=300 or y_in=−5 with grad_in=1000 → grad_out=0. With the macro defined, clamp_cnt increments by 2.
- Stream 8 back-to-back beats with out_ready held low for 5 cycles mid-stream:
  - in_ready drops after 2 beats are buffered.
  - grad_out holds stable while stalled.
  - All 8 results arrive in order with none lost.
- Assert rst for 1 cycle with 2 beats in flight → next cycle out_valid=0, grad_out=0, in_ready=1. A new beat after reset emerges correctly 2 cycles later.
- Exhaustive sweep: y_in from −16 to 272 × grad_in ∈ {−32768, −1, 0, 1, 32767}, compared against a floor-arithmetic reference model.

Source files
------------

// File: rtl/pwl_sigmoid_pkg.sv
// Shared Q8.8 constants and types for the PWL sigmoid forward/backward blocks.
package pwl_sigmoid_pkg;

  localparam int DATA_W  = 16;   // Q8.8 data width
  localparam int FRAC_W  = 8;    // fractional bits
  localparam int ONE_Q88 = 256;  // 1.0 in Q8.8

  // Clamp bounds applied to the saved forward output y
  localparam int Y_MIN = 0;
  localparam int Y_MAX = 256;

  // y*(1-y) peaks at 0.25 -> 64 in Q8.8, so 7 bits suffice
  localparam int S_W   = 7;
  localparam int CNT_W = 16;

  // Stage-1 payload: derivative factor plus the upstream gradient
  typedef struct packed {
    logic [S_W-1:0]           s;
    logic signed [DATA_W-1:0] grad;
  } s1_payload_t;

endpackage

// File: rtl/pwl_pipe_stage.sv
// Generic valid/ready register slice, parameterised by payload width.
// Full-throughput: accepts a new beat in the same cycle the held one drains.
module pwl_pipe_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // Slice can take a beat when empty or when its current beat leaves this cycle
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: load on accept, otherwise hold (keeps output stable under stall)
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, because the block's visible output must read 0 after reset.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pwl_sigmoid_backward.sv
// Backward pass of the PWL sigmoid: grad_out = grad_in * y * (1 - y), Q8.8.
// Two register slices (stage 1: derivative factor, stage 2: product).
// Optional macro PWL_SIG_BWD_CLAMP_CNT_EN adds a saturating count of
// accepted inputs whose y_in fell outside 0..256.
module pwl_sigmoid_backward #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] grad_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] grad_out
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
  ,
  output logic [15:0]              clamp_cnt
`endif
);

  import pwl_sigmoid_pkg::*;

  localparam int P_W = DATA_W + FRAC_W;
  localparam logic signed [DATA_W-1:0] Y_LO = DATA_W'(Y_MIN);
  localparam logic signed [DATA_W-1:0] Y_HI = DATA_W'(Y_MAX);

  logic [8:0]        yc;
  logic [8:0]        one_minus_yc;
  logic [14:0]       sq;
  logic [S_W-1:0]    s;
  s1_payload_t       s1_in, s1_out;
  logic              s1_valid, s1_ready;
  logic signed [P_W-1:0]    p;
  logic signed [DATA_W-1:0] grad_s2;

  // Stage-1 arithmetic: clamp y to [0, 1.0], then s = y*(1-y) in Q8.8 (floor)
  always_comb begin
    yc = '0;
    if (y_in < Y_LO)      yc = '0;
    else if (y_in > Y_HI) yc = 9'(Y_MAX);
    else                  yc = y_in[8:0];
    one_minus_yc = 9'(ONE_Q88) - yc;
    sq           = 15'(yc) * 15'(one_minus_yc);
    s            = S_W'(sq >> FRAC_W);
    s1_in.s      = s;
    s1_in.grad   = grad_in;
  end

  pwl_pipe_stage #(.W($bits(s1_payload_t))) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_out)
  );

  // Stage-2 arithmetic: signed grad times unsigned s, arithmetic shift gives floor
  always_comb begin
    p       = P_W'($signed(s1_out.grad)) * P_W'($signed({1'b0, s1_out.s}));
    grad_s2 = DATA_W'(p >>> FRAC_W);
  end

  pwl_pipe_stage #(.W(DATA_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   (grad_s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (grad_out)
  );

`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
  logic             out_of_range;
  logic [CNT_W-1:0] clamp_cnt_d, clamp_cnt_q;

  // Count accepted beats whose y lies outside the clamp range, saturating
  always_comb begin
    out_of_range = (y_in < Y_LO) || (y_in > Y_HI);
    clamp_cnt_d  = clamp_cnt_q;
    if (in_valid && in_ready && out_of_range && (clamp_cnt_q != '1))
      clamp_cnt_d = clamp_cnt_q + 16'd1;
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) clamp_cnt_q <= '0;
    else     clamp_cnt_q <= clamp_cnt_d;
  end

  assign clamp_cnt = clamp_cnt_q;
`endif

endmodule

// File: tb/tb_pwl_sigmoid_backward.sv
// Self-checking bench for pwl_sigmoid_backward: directed cases, a stalled
// stream, reset with beats in flight, and a sweep of y against a reference model.
module tb_pwl_sigmoid_backward;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] y_in, grad_in, grad_out;
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
  logic [15:0] clamp_cnt;
  int clamp_model = 0;
`endif

  typedef struct { int exp; int age; } beat_t;
  beat_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_out    = 0;

  pwl_sigmoid_backward #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .grad_in   (grad_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out)
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
    ,
    .clamp_cnt (clamp_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: dL/dx = g * y * (1 - y) with y clamped to [0, 1], floor rounding
  function automatic int ref_grad(input int y, input int g);
    int yc, s, p;
    yc = (y < 0) ? 0 : ((y > 256) ? 256 : y);
    s  = (yc * (256 - yc)) / 256;
    p  = g * s;
    return (p >= 0) ? (p / 256) : -((-p + 255) / 256);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against model, advance model at posedge
  task automatic step(input logic r, input logic v, input logic signed [15:0] y,
                      input logic signed [15:0] g, input logic ordy, output bit acc);
    bit acc_out;
    bit exp_valid;
    rst = r; in_valid = v; y_in = y; grad_in = g; out_ready = ordy;
    #1;
    exp_valid = (sb.size() > 0) && (sb[0].age >= 2);
    if (!r) begin
      check("in_ready", in_ready, (sb.size() < 2) || ordy);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) check("grad_out", grad_out, sb[0].exp);
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
      check("clamp_cnt", clamp_cnt, clamp_model);
`endif
    end
    acc     = v && in_ready && !r;
    acc_out = out_valid && ordy && !r;
    @(posedge clk);
    if (r) begin
      sb.delete();
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
      clamp_model = 0;
`endif
    end else begin
      if (acc_out && sb.size() > 0) begin
        void'(sb.pop_front());
        n_out++;
      end
      foreach (sb[i]) sb[i].age++;
      if (acc) begin
        beat_t b;
        b.exp = ref_grad(int'(y), int'(g));
        b.age = 1;
        sb.push_back(b);
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
        if ((int'(y) < 0 || int'(y) > 256) && clamp_model < 65535) clamp_model++;
`endif
      end
    end
    @(negedge clk);
  endtask

  // Single beat with no backpressure: valid must appear exactly two cycles later
  task automatic directed(input string tag, input int y, input int g, input int exp);
    bit a;
    step(1'b0, 1'b1, 16'(y), 16'(g), 1'b1, a);
    check({tag, "_accept"}, a, 1);
    check({tag, "_lat1_valid"}, out_valid, 0);
    step(1'b0, 1'b0, '0, '0, 1'b1, a);
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_lat2_data"}, grad_out, exp);
    step(1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  initial begin
    bit a;
    int gl[5];
    int out0;
    int idx;
    int cyc;
    int ny;
    logic signed [15:0] ys[8];
    logic signed [15:0] gs[8];
    logic signed [15:0] yv, gv;
    int sy[$];
    int sg[$];

    rst = 1'b1; in_valid = 1'b0; y_in = '0; grad_in = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, '0, '0, 1'b0, a);
    step(1'b1, 1'b0, '0, '0, 1'b0, a);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_grad_out", grad_out, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed values, floor behaviour and clamp boundaries
    directed("peak",     128,   256,  64);
    directed("y64_neg",   64,  -256, -48);
    directed("floor",    128,    -1,  -1);
    directed("y_over",   300,  1000,   0);
    directed("y_under",   -5,  1000,   0);
`ifdef PWL_SIG_BWD_CLAMP_CNT_EN
    check("clamp_cnt_two", clamp_cnt, 2);
`endif

    // Eight back-to-back beats, downstream stalled for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      ys[i] = 16'(int'($urandom_range(0, 320)) - 32);
      gs[i] = 16'($urandom);
    end
    out0 = n_out; idx = 0; cyc = 0;
    while ((idx < 8 || sb.size() > 0) && cyc < 200) begin
      yv = (idx < 8) ? ys[idx] : '0;
      gv = (idx < 8) ? gs[idx] : '0;
      step(1'b0, idx < 8, yv, gv, !(cyc >= 3 && cyc < 8), a);
      if (a) idx++;
      cyc++;
    end
    check("stream_count", n_out - out0, 8);
    check("stream_drained", sb.size(), 0);

    // Reset with two beats in flight drops them
    step(1'b0, 1'b1, 16'sd64, 16'sd1000, 1'b0, a);
    step(1'b0, 1'b1, 16'sd128, 16'sd2000, 1'b0, a);
    step(1'b1, 1'b1, 16'sd100, 16'sd3000, 1'b1, a);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_grad_out", grad_out, 0);
    check("midrst_in_ready", in_ready, 1);
    directed("post_rst", 100, 500, 117);

    // Sweep y over and beyond the clamp range against the reference model
    gl = '{-32768, -1, 0, 1, 32767};
    for (int y = -16; y <= 272; y++) begin
      for (int k = 0; k < 5; k++) begin
        sy.push_back(y);
        sg.push_back(gl[k]);
      end
    end
    ny = sy.size();
    out0 = n_out; idx = 0; cyc = 0;
    while ((idx < ny || sb.size() > 0) && cyc < 20000) begin
      yv = (idx < ny) ? 16'(sy[idx]) : '0;
      gv = (idx < ny) ? 16'(sg[idx]) : '0;
      step(1'b0, idx < ny, yv, gv, $urandom_range(0, 3) != 0, a);
      if (a) idx++;
      cyc++;
    end
    check("sweep_count", n_out - out0, ny);
    check("sweep_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
